// File: rtl/sa_pkg.sv
// sa_pkg: shared definitions for the parametrised systolic-array controller.
//   - sa_state_e     : controller phases (load operands, compute wavefront, drain output)
//   - sel_zero       : feed-select value that routes zero into a PE row/column (equals N)
//   - beats_per_acc  : output beats needed to serialise one accumulator
//   - weight_base    : first operand-memory address of the weight block W[i][k]
//   - input_base     : first operand-memory address of the input block X[k][j]
package sa_pkg;

    typedef enum logic [1:0] {
        StLoad,
        StCompute,
        StOutput
    } sa_state_e;

    function automatic int unsigned sel_zero(int unsigned n);
        return n;
    endfunction

    function automatic int unsigned beats_per_acc(int unsigned acc_w, int unsigned out_w);
        return acc_w / out_w;
    endfunction

    function automatic int unsigned weight_base();
        return 0;
    endfunction

    function automatic int unsigned input_base(int unsigned n);
        return n * n;
    endfunction

endpackage

// File: rtl/sa_skew_sel.sv
// sa_skew_sel: combinational generator of the skewed feed selects.
// Field i is (t - i) while that value lies in 0..N-1, otherwise sel_zero(N).
// The rule is identical for rows (a_sel) and columns (b_sel), so one instance serves both.
// Ports:
//   active  in  1          high only during the compute wavefront; low forces all fields to zero-feed
//   t       in  T_W        wavefront step counter
//   sel     out N*SEL_W    packed select fields, field 0 in the LSBs
module sa_skew_sel
    import sa_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int unsigned SEL_W = $clog2(N + 1),
    parameter int unsigned T_W   = 3
) (
    input  logic               active,
    input  logic [T_W-1:0]     t,
    output logic [N*SEL_W-1:0] sel
);

    int unsigned t_ext;
    assign t_ext = 32'(t);

    for (genvar i = 0; i < N; i++) begin : g_field
        logic in_window;
        assign in_window = active && (t_ext >= i) && (t_ext < i + N);
        assign sel[i*SEL_W +: SEL_W] = in_window ? SEL_W'(t_ext - i) : SEL_W'(sel_zero(N));
    end

endmodule

// File: rtl/sa_ctrl_param.sv
// sa_ctrl_param: control unit for an N x N output-stationary systolic array.
// Loads 2*N*N operand bytes into the operand memory, runs a 3N-1 cycle skewed compute
// wavefront, then serialises the N*N accumulators (MSB slice first) over a valid/ready port.
// Build option: define OUT_HOLD_EN to snapshot the accumulators on entry to the output
// phase and let the next operand load overlap the output drain.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   load_en               load enable; low during loading restarts the address at 0
//   in_valid / in_ready   operand byte handshake from the host
//   mem_addr / mem_we     operand memory write address / strobe
//   clear                 PE accumulators take the product instead of accumulating (t = 0)
//   a_sel / b_sel         per-row / per-column feed selects (value N = feed zero)
//   c_flat                accumulators, row-major, c[0][0] in the LSBs
//   data_out / out_valid / out_ready   serialised result beats
//   done                  one-cycle pulse after the last beat is taken
module sa_ctrl_param
    import sa_pkg::*;
#(
    parameter int unsigned N      = 2,
    parameter int unsigned ACC_W  = 16,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned SEL_W  = $clog2(N + 1),
    parameter int unsigned ADDR_W = $clog2(2 * N * N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_en,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_we,
    output logic                 clear,
    output logic [N*SEL_W-1:0]   a_sel,
    output logic [N*SEL_W-1:0]   b_sel,
    input  logic [N*N*ACC_W-1:0] c_flat,
    output logic [OUT_W-1:0]     data_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 done
);

    localparam int unsigned BPA       = beats_per_acc(ACC_W, OUT_W);
    localparam int unsigned BEATS     = N * N * BPA;
    localparam int unsigned BEAT_W    = $clog2(BEATS);
    localparam int unsigned T_LAST    = 3 * N - 2;
    localparam int unsigned T_W       = $clog2(T_LAST + 1);
    localparam int unsigned LAST_ADDR = input_base(N) + N * N - 1;

    sa_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [T_W-1:0]     t_q, t_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic               done_q, done_d;
    logic               load_phase;
    logic               load_complete;
    logic               load_done_q;
    logic               skew_active;
    logic [N*SEL_W-1:0] skew_sel;
    logic [N*N*ACC_W-1:0] out_src;

`ifdef OUT_HOLD_EN
    logic [N*N*ACC_W-1:0] snap_q;

    // Loading continues during the drain until a full operand set is held.
    assign load_phase = (state_q == StLoad) || (state_q == StOutput && !load_done_q);
    assign out_src    = snap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q      <= '0;
            load_done_q <= 1'b0;
        end else begin
            if (state_q == StCompute && state_d == StOutput) begin
                snap_q <= c_flat;
            end
            if (state_q == StOutput && state_d == StCompute) begin
                load_done_q <= 1'b0;
            end else if (state_q == StOutput && load_complete) begin
                load_done_q <= 1'b1;
            end
        end
    end
`else
    assign load_phase  = (state_q == StLoad);
    assign load_done_q = 1'b0;
    assign out_src     = c_flat;
`endif

    sa_skew_sel #(
        .N     (N),
        .SEL_W (SEL_W),
        .T_W   (T_W)
    ) u_skew (
        .active (skew_active),
        .t      (t_q),
        .sel    (skew_sel)
    );

    assign a_sel = skew_sel;
    assign b_sel = skew_sel;

    // Beat b: accumulator b/BPA, slice BPA-1 - b%BPA (most significant slice first).
    logic [OUT_W-1:0] beat_arr [BEATS];
    for (genvar g = 0; g < BEATS; g++) begin : g_beat
        localparam int unsigned Off = (g / BPA) * ACC_W + (BPA - 1 - g % BPA) * OUT_W;
        assign beat_arr[g] = out_src[Off +: OUT_W];
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        t_d           = t_q;
        beat_d        = beat_q;
        done_d        = 1'b0;
        in_ready      = 1'b0;
        clear         = 1'b0;
        out_valid     = 1'b0;
        skew_active   = 1'b0;
        load_complete = 1'b0;

        if (load_phase) begin
            in_ready = load_en;
            if (!load_en) begin
                addr_d = ADDR_W'(weight_base());
            end else if (in_valid) begin
                if (addr_q == ADDR_W'(LAST_ADDR)) begin
                    addr_d        = ADDR_W'(weight_base());
                    load_complete = 1'b1;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
        end

        unique case (state_q)
            StLoad: begin
                if (load_complete) begin
                    state_d = StCompute;
                    t_d     = '0;
                end
            end
            StCompute: begin
                skew_active = 1'b1;
                clear       = (t_q == '0);
                if (t_q == T_W'(T_LAST)) begin
                    state_d = StOutput;
                    beat_d  = '0;
                end else begin
                    t_d = t_q + T_W'(1);
                end
            end
            StOutput: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        done_d  = 1'b1;
                        beat_d  = '0;
                        t_d     = '0;
                        state_d = (load_done_q || load_complete) ? StCompute : StLoad;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StLoad;
            addr_q  <= '0;
            t_q     <= '0;
            beat_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            t_q     <= t_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
        end
    end

    assign mem_addr = addr_q;
    assign mem_we   = in_valid & in_ready;
    assign done     = done_q;
    assign data_out = out_valid ? beat_arr[beat_q] : '0;

endmodule
